// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer/status controller of the async FIFO: binary/Gray write pointer, full,
// almost-full and free-space count. Optional sticky overflow flag under WPTR_OVF_DETECT_EN.
module wptr_full_ctrl #(
    parameter int unsigned ADDRSIZE  = 4,
    parameter int unsigned AF_THRESH = 2
) (
    input  logic                wclk,
    input  logic                rst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic                wen,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
`ifdef WPTR_OVF_DETECT_EN
    output logic                wovf,
`endif
    output logic [ADDRSIZE:0]   wfree
);

    localparam int unsigned DEPTH = 1 << ADDRSIZE;
    localparam int unsigned PtrW  = ADDRSIZE + 1;

    if (ADDRSIZE < 2) begin : g_bad_addrsize
        $error("wptr_full_ctrl: ADDRSIZE must be at least 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH - 1)) begin : g_bad_thresh
        $error("wptr_full_ctrl: AF_THRESH must lie in 1..DEPTH-1");
    end

    logic [ADDRSIZE:0] wbin_q, wbin_d;
    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic [ADDRSIZE:0] wfree_q, wfree_d;
    logic              wfull_q, wfull_d;
    logic              walmost_full_q, walmost_full_d;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] used;

    assign wen = winc & ~wfull_q;

    always_comb begin
        rbin_s = '0;
        rbin_s[ADDRSIZE] = wq2_rptr[ADDRSIZE];
        // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
        for (int i = int'(ADDRSIZE) - 1; i >= 0; i--) begin
            rbin_s[i] = rbin_s[i+1] ^ wq2_rptr[i];
        end
    end

    always_comb begin
        wbin_d = wbin_q + {{ADDRSIZE{1'b0}}, wen};
        wptr_d = (wbin_d >> 1) ^ wbin_d;
        wfull_d = (wptr_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
        used = wbin_d - rbin_s;
        wfree_d = PtrW'(DEPTH) - used;
        walmost_full_d = (wfree_d <= PtrW'(AF_THRESH));
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wfree_q        <= PtrW'(DEPTH);
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wfree_q        <= wfree_d;
        end
    end

    assign waddr        = wbin_q[ADDRSIZE-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wfree        = wfree_q;

`ifdef WPTR_OVF_DETECT_EN
    logic wovf_q, wovf_d;

    // Sticky: a rejected write is remembered until reset.
    assign wovf_d = wovf_q | (winc & wfull_q);

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            wovf_q <= 1'b0;
        end else begin
            wovf_q <= wovf_d;
        end
    end

    assign wovf = wovf_q;
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed self-checking bench for wptr_full_ctrl (ADDRSIZE=4, AF_THRESH=2).
module tb_wptr_full_ctrl;

    logic       wclk = 1'b0;
    logic       rst;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wfree;
`ifdef WPTR_OVF_DETECT_EN
    logic       wovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    wptr_full_ctrl #(
        .ADDRSIZE  (4),
        .AF_THRESH (2)
    ) dut (
        .wclk         (wclk),
        .rst          (rst),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .wen          (wen),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
`ifdef WPTR_OVF_DETECT_EN
        .wovf         (wovf),
`endif
        .wfree        (wfree)
    );

    always #5 wclk = ~wclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] gray5(input int unsigned b);
        logic [4:0] t;
        t = b[4:0];
        return t ^ (t >> 1);
    endfunction

    initial begin
        rst      = 1'b1;
        winc     = 1'b1;
        wq2_rptr = 5'd0;
        repeat (3) @(negedge wclk);

        // Reset state; wen follows winc since wfull is clear
        check_eq("rst_wptr", wptr, 5'b00000);
        check_eq("rst_waddr", waddr, 0);
        check_eq("rst_wfull", wfull, 0);
        check_eq("rst_walmost", walmost_full, 0);
        check_eq("rst_wfree", wfree, 16);
        check_eq("rst_wen", wen, 1);
`ifdef WPTR_OVF_DETECT_EN
        check_eq("rst_wovf", wovf, 0);
`endif

        // Fill with the read pointer parked at 0
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge wclk);
            check_eq("fill_wfree", wfree, 16 - k);
            check_eq("fill_walmost", walmost_full, (k >= 14) ? 1 : 0);
            check_eq("fill_wfull", wfull, (k == 16) ? 1 : 0);
            check_eq("fill_wptr", wptr, gray5(k));
            check_eq("fill_waddr", waddr, k % 16);
            check_eq("fill_wen", wen, (k == 16) ? 0 : 1);
        end
        check_eq("full_wptr", wptr, 5'b11000);

        // Writes while full are dropped
        for (int k = 0; k < 3; k++) begin
            @(negedge wclk);
            check_eq("wwf_wptr", wptr, 5'b11000);
            check_eq("wwf_wfree", wfree, 0);
            check_eq("wwf_wfull", wfull, 1);
            check_eq("wwf_wen", wen, 0);
            check_eq("wwf_waddr", waddr, 0);
`ifdef WPTR_OVF_DETECT_EN
            check_eq("wwf_wovf", wovf, 1);
`endif
        end

        // One read slot released
        winc     = 1'b0;
        wq2_rptr = 5'b00001;
        @(negedge wclk);
        check_eq("rel_wfull", wfull, 0);
        check_eq("rel_wfree", wfree, 1);
        check_eq("rel_walmost", walmost_full, 1);
        check_eq("rel_wptr", wptr, 5'b11000);
        winc = 1'b1;
        @(negedge wclk);
        check_eq("refill_wfull", wfull, 1);
        check_eq("refill_wptr", wptr, 5'b11001);
        check_eq("refill_wfree", wfree, 0);
        check_eq("refill_waddr", waddr, 1);

        // Async reset between edges while full
        winc = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_wfull", wfull, 0);
        check_eq("arst_wptr", wptr, 0);
        check_eq("arst_waddr", waddr, 0);
        check_eq("arst_wfree", wfree, 16);
        check_eq("arst_walmost", walmost_full, 0);
`ifdef WPTR_OVF_DETECT_EN
        check_eq("arst_wovf", wovf, 0);
`endif
        @(negedge wclk);
        wq2_rptr = 5'd0;
        rst      = 1'b0;
        winc     = 1'b1;

        // Wrap with the read pointer trailing two cycles behind
        for (int e = 1; e <= 40; e++) begin
            @(negedge wclk);
            check_eq("wrap_wptr", wptr, gray5(e % 32));
            check_eq("wrap_wfull", wfull, 0);
            check_eq("wrap_wfree", wfree, (e == 1) ? 15 : 14);
            check_eq("wrap_walmost", walmost_full, 0);
            wq2_rptr = gray5((e - 1) % 32);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
- Write-domain controller of the async FIFO; the write-side counterpart of the read-pointer-to-write-clock synchronizer.
- Maintains the binary/Gray write pointer and drives the memory write address and enable.
- Consumes the twice-synchronized Gray read pointer and produces registered full, almost-full and free-space status.
- Its Gray pointer output feeds the write-to-read synchronizer in the read domain.

Parameters:
- ADDRSIZE, 4, FIFO address width; DEPTH = 2**ADDRSIZE entries.
- AF_THRESH, 2, almost-full asserts when free entries <= AF_THRESH. Legal range 1..DEPTH-1; elaboration error otherwise.

Ports:
- wclk  input  1  write clock.
- rst  input  1  reset, asynchronous, active-high.
- winc  input  1  write request for this cycle.
- wq2_rptr  input  ADDRSIZE+1  Gray read pointer, already synchronized into wclk.
- wen  output  1  memory write enable = winc & ~wfull (combinational).
- waddr  output  ADDRSIZE  memory write address = wbin[ADDRSIZE-1:0].
- wptr  output  ADDRSIZE+1  registered Gray write pointer, to the read-side synchronizer.
- wfull  output  1  registered full flag.
- walmost_full  output  1  registered almost-full flag.
- wfree  output  ADDRSIZE+1  registered free-entry count, 0..DEPTH.

Behaviour:
- Internal state: wbin, an (ADDRSIZE+1)-bit binary pointer. wptr, wfull, walmost_full and wfree are registers on the posedge of wclk, with async reset.
- Reset values:
  - wbin = 0, wptr = 0, wfull = 0, walmost_full = 0, wfree = DEPTH.
  - Reset asserted mid-operation clears all of these immediately, independent of wclk.
  - On the first edge after reset release, outputs reflect the current wq2_rptr.
- Next-state computation:
  - wbinnext = wbin + (winc & ~wfull), modulo 2**(ADDRSIZE+1). Natural wrap 2*DEPTH-1 -> 0.
  - wgraynext = (wbinnext >> 1) ^ wbinnext.
  - On each edge: wbin <= wbinnext, wptr <= wgraynext.
- Full:
  - wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - wfull therefore asserts on the same edge that accepts the DEPTH-th outstanding write. There is no one-cycle lag.
- Free count:
  - rbin_s = Gray-to-binary of wq2_rptr, an XOR prefix from the MSB down.
  - used = (wbinnext - rbin_s) mod 2**(ADDRSIZE+1).
  - wfree <= DEPTH - used.
- Almost-full: walmost_full <= (DEPTH - used) <= AF_THRESH.
- Consistency rules:
  - wfull == 1 implies wfree == 0 and walmost_full == 1 at every edge.
  - All three status outputs derive from the same wbinnext and the same wq2_rptr sample.
- Write while full: winc=1 with wfull=1 gives wen=0 and no pointer change. The memory is not written and the status is unchanged unless wq2_rptr moves.
- Simultaneous write and read-pointer advance in the same cycle:
  - Both are accounted for in the same edge.
  - From full, the write is rejected (wfull is still 1 in that cycle). The flag drops on that edge because of the read advance.
- Pessimism: status is pessimistic, since the read pointer is two or more cycles old. This means full may be reported late to deassert but never late to assert, and overflow is impossible.
- wq2_rptr: assumed to change by at most one Gray step per wclk. Multi-step jumps are still handled arithmetically, with no special case.

Optional Feature:
- Macro WPTR_OVF_DETECT_EN.
- When defined:
  - Adds output wovf (1 bit), a sticky overflow flag.
  - wovf sets on any edge where winc=1 and wfull=1.
  - wovf clears only on rst (reset value 0).
  - It does not affect wen or the pointers.
- When undefined: the port does not exist and no logic is generated. All other behaviour is identical.

Test Plan:
- Reset: ADDRSIZE=4, hold rst=1 -> wptr=5'b00000, waddr=0, wfull=0, walmost_full=0, wfree=16, wen=winc&0... no: wen=winc (wfull=0).
- Fill with wq2_rptr=0:
  - 16 consecutive winc=1 -> wfree decrements 16..0.
  - walmost_full=1 on the edge of the 14th write (wfree=2).
  - wfull=1 on the edge of the 16th write; wptr=5'b11000; waddr=0.
- Write while full: winc=1 for 3 cycles with wfull=1 -> wen=0, wptr stays 5'b11000, wfree=0. With WPTR_OVF_DETECT_EN: wovf=1 after the first such edge and stays 1.
- Read release: with the FIFO full, set wq2_rptr=5'b00001 -> next edge wfull=0, wfree=1, walmost_full=1. Then winc=1 -> wfull=1 again, wptr=5'b11001.
- Wrap: 40 writes, with wq2_rptr tracking each write's Gray value 2 cycles later -> wbin wraps 31->0 (wptr 5'b10000 -> 5'b00000). wfull never asserts; wfree never drops below 14.
- Async reset mid-operation: rst pulsed between clock edges while wfull=1 -> wfull, wptr and waddr go to 0 and wfree to 16 immediately, without waiting for a wclk edge. With the macro defined, wovf also clears to 0.
